seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_det_pkg.sv | 30 +++
 rtl/sat_counter.sv | 33 +++
 rtl/seq_detect_param.sv | 101 ++++++++++
 tb/tb_seq_detect_param.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg : shared length-width helper and match-window compare
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_det_pkg;

  localparam int MAX_LEN_LIMIT = 16;
  localparam int LEN_W_LIMIT   = $clog2(MAX_LEN_LIMIT + 1);

  // LEN_W for a given MAX_LEN: wide enough to hold the value MAX_LEN itself
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic logic window_match(input logic [MAX_LEN_LIMIT-1:0] win,
                                        input logic [MAX_LEN_LIMIT-1:0] pat,
                                        input logic [LEN_W_LIMIT-1:0]   len);
    logic [MAX_LEN_LIMIT-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_LEN_LIMIT; i++) begin
      if (i < int'(len)) mask[i] = 1'b1;
    end
    return ((win ^ pat) & mask) == '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter : up-counter that sticks at all-ones instead of wrapping
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param : runtime-configurable serial pattern detector (Mealy)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'b0000_1101),
  parameter int                 DEF_LEN = 4,
  localparam int                LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               en,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_ovl,
  output logic               y,
  output logic               y_q,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W:0]   FILL_INC = (LEN_W+1)'(1);

  // The oldest history bit never reaches the compare window, so it is not kept
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic               ovl_q, ovl_d;

  logic [MAX_LEN-1:0] win;
  logic               len_ok;
  logic               fill_ok;
  logic               win_ok;

  assign win     = {hist_q, din};
  assign len_ok  = (len_q != '0);
  assign fill_ok = ({1'b0, fill_q} + FILL_INC) >= {1'b0, len_q};
  assign win_ok  = window_match(MAX_LEN_LIMIT'(win), MAX_LEN_LIMIT'(pat_q),
                                LEN_W_LIMIT'(len_q));
  assign y       = ~rst & en & ~cfg_we & len_ok & fill_ok & win_ok;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    if (cfg_we) begin
      pat_d  = cfg_pat;
      len_d  = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      ovl_d  = cfg_ovl;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = win[MAX_LEN-2:0];
      // Non-overlap restarts the fill so the next match needs a full fresh window
      if (y && !ovl_q)           fill_d = '0;
      else if (fill_q != LEN_MAX) fill_d = fill_q + LEN_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PAT;
      len_q  <= LEN_W'(DEF_LEN);
      ovl_q  <= 1'b1;
      y_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      y_q    <= y;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (y),
    .cnt (match_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_param : directed bench, default DUT plus a CNT_W=2 copy
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       en = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pat = 8'h00;
  logic [3:0] cfg_len = 4'd0;
  logic       cfg_ovl = 1'b0;
  logic       y, y_q, y2, y2_q;
  logic [7:0] cnt;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .cfg_we(cfg_we),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .y(y), .y_q(y_q), .match_cnt(cnt)
  );

  seq_detect_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .en(en), .cfg_we(cfg_we),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .y(y2), .y_q(y2_q), .match_cnt(cnt2)
  );

  task automatic drive(input logic r, input logic e, input logic b);
    @(negedge clk);
    rst = r; en = e; din = b; cfg_we = 1'b0;
    #1;
  endtask

  task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic o,
                           input logic e, input logic b);
    @(negedge clk);
    rst = 1'b0; cfg_we = 1'b1; cfg_pat = p; cfg_len = l; cfg_ovl = o; en = e; din = b;
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if ({y, y2} !== 2'b00) begin
      errors++; $display("FAIL reset_y: y=%b y2=%b expected 0 0", y, y2);
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt !== 8'd0 || cnt2 !== 2'd0 || y_q !== 1'b0 || y2_q !== 1'b0) begin
      errors++; $display("FAIL reset_state: cnt=%0d cnt2=%0d y_q=%b y2_q=%b expected 0 0 0 0", cnt, cnt2, y_q, y2_q);
    end
  endtask

  task automatic test_overlap;
    logic [6:0] bits, ey;
    logic prev;
    bits = 7'b1101101; ey = 7'b0001001; prev = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      drive(1'b0, 1'b1, bits[i]);
      checks++;
      if ({y, y_q, y2, y2_q} !== {ey[i], prev, ey[i], prev}) begin
        errors++; $display("FAIL overlap bit%0d: y,y_q,y2,y2_q=%b%b%b%b expected %b%b%b%b", 7-i, y, y_q, y2, y2_q, ey[i], prev, ey[i], prev);
      end
      prev = ey[i];
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt !== 8'd2 || cnt2 !== 2'd2 || y_q !== 1'b1) begin
      errors++; $display("FAIL overlap_cnt: cnt=%0d cnt2=%0d y_q=%b expected 2 2 1", cnt, cnt2, y_q);
    end
  endtask

  task automatic test_non_overlap;
    logic [6:0] bits, ey;
    logic prev;
    configure(8'h0D, 4'd4, 1'b0, 1'b0, 1'b0);
    bits = 7'b1101101; ey = 7'b0001000; prev = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      drive(1'b0, 1'b1, bits[i]);
      checks++;
      if ({y, y_q, y2, y2_q} !== {ey[i], prev, ey[i], prev}) begin
        errors++; $display("FAIL non_overlap bit%0d: y,y_q,y2,y2_q=%b%b%b%b expected %b%b%b%b", 7-i, y, y_q, y2, y2_q, ey[i], prev, ey[i], prev);
      end
      prev = ey[i];
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt !== 8'd3 || cnt2 !== 2'd3) begin
      errors++; $display("FAIL non_overlap_cnt: cnt=%0d cnt2=%0d expected 3 3", cnt, cnt2);
    end
  endtask

  task automatic test_run_of_ones;
    logic [4:0] ey;
    logic prev;
    for (int m = 1; m >= 0; m--) begin
      configure(8'h07, 4'd3, m[0], 1'b0, 1'b0);
      ey = m[0] ? 5'b00111 : 5'b00100;
      prev = 1'b0;
      for (int i = 4; i >= 0; i--) begin
        drive(1'b0, 1'b1, 1'b1);
        checks++;
        if ({y, y_q, y2, y2_q} !== {ey[i], prev, ey[i], prev}) begin
          errors++; $display("FAIL ones ovl=%0d bit%0d: y,y_q,y2,y2_q=%b%b%b%b expected %b%b%b%b", m, 5-i, y, y_q, y2, y2_q, ey[i], prev, ey[i], prev);
        end
        prev = ey[i];
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt !== 8'd7 || cnt2 !== 2'd3) begin
      errors++; $display("FAIL saturation: cnt=%0d cnt2=%0d expected 7 3", cnt, cnt2);
    end
  endtask

  task automatic test_cfg_priority;
    logic [3:0] bits, ey;
    logic prev;
    configure(8'h0D, 4'd4, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    configure(8'h0D, 4'd4, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({y, y2} !== 2'b00) begin
      errors++; $display("FAIL cfg_priority_y: y=%b y2=%b expected 0 0", y, y2);
    end
    bits = 4'b1101; ey = 4'b0001; prev = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      drive(1'b0, 1'b1, bits[i]);
      checks++;
      if ({y, y_q} !== {ey[i], prev}) begin
        errors++; $display("FAIL cfg_clear bit%0d: y,y_q=%b%b expected %b%b", 4-i, y, y_q, ey[i], prev);
      end
      prev = ey[i];
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt !== 8'd8 || cnt2 !== 2'd3) begin
      errors++; $display("FAIL cfg_priority_cnt: cnt=%0d cnt2=%0d expected 8 3", cnt, cnt2);
    end
  endtask

  task automatic test_enable_hold;
    configure(8'h0D, 4'd4, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if ({y, y_q} !== 2'b00) begin
      errors++; $display("FAIL en_low: y,y_q=%b%b expected 00", y, y_q);
    end
    drive(1'b0, 1'b1, 1'b1);
    checks++;
    if ({y, y_q} !== 2'b10) begin
      errors++; $display("FAIL en_resume: y,y_q=%b%b expected 10", y, y_q);
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt !== 8'd9 || y_q !== 1'b1) begin
      errors++; $display("FAIL en_hold_cnt: cnt=%0d y_q=%b expected 9 1", cnt, y_q);
    end
  endtask

  task automatic test_reset_midstream;
    logic [6:0] bits, ey;
    logic prev;
    configure(8'h05, 4'd3, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if ({y, y2} !== 2'b00) begin
      errors++; $display("FAIL rst_forces_y: y=%b y2=%b expected 0 0", y, y2);
    end
    bits = 7'b1101101; ey = 7'b0001001; prev = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      drive(1'b0, 1'b1, bits[i]);
      if (i == 6) begin
        checks++;
        if (cnt !== 8'd0 || cnt2 !== 2'd0 || y_q !== 1'b0) begin
          errors++; $display("FAIL rst_mid_state: cnt=%0d cnt2=%0d y_q=%b expected 0 0 0", cnt, cnt2, y_q);
        end
      end
      checks++;
      if ({y, y_q} !== {ey[i], prev}) begin
        errors++; $display("FAIL rst_mid bit%0d: y,y_q=%b%b expected %b%b", 7-i, y, y_q, ey[i], prev);
      end
      prev = ey[i];
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt !== 8'd2 || cnt2 !== 2'd2) begin
      errors++; $display("FAIL rst_mid_cnt: cnt=%0d cnt2=%0d expected 2 2", cnt, cnt2);
    end
  endtask

  task automatic test_len_bounds;
    logic [7:0] bits, ey;
    logic prev;
    configure(8'hFF, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b1);
      checks++;
      if ({y, y2} !== 2'b00) begin
        errors++; $display("FAIL len0 bit%0d: y=%b y2=%b expected 0 0", i + 1, y, y2);
      end
    end
    configure(8'hB6, 4'd9, 1'b1, 1'b0, 1'b0);
    bits = 8'b1011_0110; ey = 8'b0000_0001; prev = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      drive(1'b0, 1'b1, bits[i]);
      checks++;
      if ({y, y_q} !== {ey[i], prev}) begin
        errors++; $display("FAIL len9 bit%0d: y,y_q=%b%b expected %b%b", 8-i, y, y_q, ey[i], prev);
      end
      prev = ey[i];
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt !== 8'd3 || cnt2 !== 2'd3) begin
      errors++; $display("FAIL len_bounds_cnt: cnt=%0d cnt2=%0d expected 3 3", cnt, cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_run_of_ones();
    test_cfg_priority();
    test_enable_hold();
    test_reset_midstream();
    test_len_bounds();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
